// File: rtl/jzjpcc_mmio_pkg.sv
// Shared constants and helpers for the jzjpcc MMIO bank.
// The bank sits at the top of the 32-bit address space, growing downward
// with NUM_PORTS; the status word sits one word below the lowest port.
package jzjpcc_mmio_pkg;

  localparam logic [31:0] MMIO_TOP_ADDR = 32'hFFFF_FFFC;
  localparam int          MAX_PORTS     = 32;

  // Byte address of port 0 for a given port count (2^32 - 4*num_ports).
  // Computed downward from the top word so nothing overflows 32 bits.
  function automatic logic [31:0] port_base(input int num_ports);
    return MMIO_TOP_ADDR - 32'(4 * (num_ports - 1));
  endfunction

  // Replace only the byte lanes of old_word selected by be.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = data[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/jzjpcc_sync_chain.sv
// WIDTH-bit, STAGES-deep flop synchroniser for one external input word.
// Only q (the last stage) may be used downstream.
module jzjpcc_sync_chain
  import jzjpcc_mmio_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the input through the chain; every stage clears on reset.
  // NOTE: this array is a handful of flops, not a RAM, so resetting every
  // element is cheap and keeps the post-reset read value defined.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value
      // of its predecessor, which is what makes this a shift chain.
      stage_q[0] <= d;
      for (int k = 1; k < STAGES; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/jzjpcc_mmio_bank.sv
// Memory-mapped bank of NUM_PORTS 32-bit output registers and synchronised
// inputs, with a status word one word below port 0.
// Optional feature: define JZJPCC_MMIO_CHANGE_DETECT_EN to enable per-port
// input change flags (write-1-to-clear in the status word) and changeIrq.
module jzjpcc_mmio_bank
  import jzjpcc_mmio_pkg::*;
#(
  parameter int NUM_PORTS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:2]            address,
  input  logic                   readEnable,
  input  logic                   writeEnable,
  input  logic [3:0]             byteEnable,
  input  logic [31:0]            writeData,
  output logic [31:0]            readData,
  output logic                   hit,
  input  logic [32*NUM_PORTS-1:0] mmioInputs,
  output logic [32*NUM_PORTS-1:0] mmioOutputs,
  output logic                   changeIrq
);

  localparam int          IDX_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [31:0] BASE        = port_base(NUM_PORTS);
  localparam logic [29:0] BASE_WORD   = BASE[31:2];
  localparam logic [29:0] STATUS_WORD = BASE_WORD - 30'd1;

  logic             port_hit;
  logic             status_hit;
  logic [IDX_W-1:0] port_sel;
  logic [31:0]      status_word;
  logic [31:0]      sync_q [NUM_PORTS];
  logic [31:0]      out_q  [NUM_PORTS];

  // The window runs from BASE to the top of memory, so any word address at
  // or above BASE_WORD is a port; the offset from BASE_WORD is the index.
  assign port_hit   = (address >= BASE_WORD);
  assign status_hit = (address == STATUS_WORD);
  assign hit        = port_hit | status_hit;
  assign port_sel   = IDX_W'(address - BASE_WORD);

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    jzjpcc_sync_chain #(
      .WIDTH  (32),
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (mmioInputs[32*gi +: 32]),
      .q     (sync_q[gi])
    );
    assign mmioOutputs[32*gi +: 32] = out_q[gi];
  end

  // Output registers: byte-lane merge on a port write; reset wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) out_q[i] <= '0;
    end else if (writeEnable && port_hit) begin
      out_q[port_sel] <= merge_bytes(out_q[port_sel], writeData, byteEnable);
    end
  end

  // Registered load data: port input, status word, or 0 on a miss; holds
  // its value when no read is requested.
  always_ff @(posedge clock) begin
    if (reset) begin
      readData <= '0;
    end else if (readEnable) begin
      if (port_hit)        readData <= sync_q[port_sel];
      else if (status_hit) readData <= status_word;
      else                 readData <= '0;
    end
  end

`ifdef JZJPCC_MMIO_CHANGE_DETECT_EN
  logic [31:0]          prev_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] flags;
  logic [NUM_PORTS-1:0] set_mask;
  logic [NUM_PORTS-1:0] clr_mask;
  logic [2:0]           warm_cnt;
  logic                 detect_en;

  // Per-port set (input changed) and clear (W1C lane-enabled status write).
  // NOTE: both masks get a default before the loop so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      set_mask[i] = detect_en && (sync_q[i] != prev_q[i]);
      clr_mask[i] = writeEnable && status_hit && writeData[i] && byteEnable[i >> 3];
    end
  end

  // Warm-up counter, one-cycle history of each synchroniser output and the
  // change flags. detect_en lags saturation by one cycle so prev_q already
  // holds a settled chain value on the first compared cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      warm_cnt  <= '0;
      detect_en <= 1'b0;
      flags     <= '0;
      for (int i = 0; i < NUM_PORTS; i++) prev_q[i] <= '0;
    end else begin
      if (warm_cnt != 3'(SYNC_STAGES)) warm_cnt <= warm_cnt + 3'd1;
      detect_en <= (warm_cnt == 3'(SYNC_STAGES));
      for (int i = 0; i < NUM_PORTS; i++) prev_q[i] <= sync_q[i];
      // Set is OR-ed in after the clear so a same-cycle change wins.
      flags <= (flags & ~clr_mask) | set_mask;
    end
  end

  assign status_word = 32'(flags);
  assign changeIrq   = |flags;
`else
  assign status_word = '0;
  assign changeIrq   = 1'b0;
`endif

endmodule

// File: tb/tb_jzjpcc_mmio_bank.sv
// Directed self-checking bench for jzjpcc_mmio_bank (8 ports, 2 stages).
// Change-detection scenarios run only when JZJPCC_MMIO_CHANGE_DETECT_EN is
// defined; otherwise the status word is checked to read 0.
module tb_jzjpcc_mmio_bank;

  localparam int NP = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [31:2]      address;
  logic             readEnable;
  logic             writeEnable;
  logic [3:0]       byteEnable;
  logic [31:0]      writeData;
  logic [31:0]      readData;
  logic             hit;
  logic [32*NP-1:0] mmioInputs;
  logic [32*NP-1:0] mmioOutputs;
  logic             changeIrq;

  int tests_run    = 0;
  int tests_failed = 0;

  jzjpcc_mmio_bank #(.NUM_PORTS(NP), .SYNC_STAGES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .readEnable  (readEnable),
    .writeEnable (writeEnable),
    .byteEnable  (byteEnable),
    .writeData   (writeData),
    .readData    (readData),
    .hit         (hit),
    .mmioInputs  (mmioInputs),
    .mmioOutputs (mmioOutputs),
    .changeIrq   (changeIrq)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_addr(input logic [31:0] a);
    address = a[31:2];
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    set_addr(a);
    writeData   = d;
    byteEnable  = be;
    writeEnable = 1'b1;
    tick();
    writeEnable = 1'b0;
    byteEnable  = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    set_addr(a);
    readEnable = 1'b1;
    tick();
    readEnable = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    mmioInputs  = {NP{32'hFFFF_FFFF}};
    set_addr(32'hFFFF_FFE0);
    writeData   = 32'h1234_5678;
    byteEnable  = 4'hF;
    writeEnable = 1'b1;
    readEnable  = 1'b1;
    tick();
    tick();
    writeEnable = 1'b0;
    readEnable  = 1'b0;
    byteEnable  = 4'h0;
    tests_run++;
    if (mmioOutputs !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h want 0", mmioOutputs);
    end
    tests_run++;
    if (readData !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_readdata: got %h want 0", readData);
    end
    tests_run++;
    if (changeIrq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_irq: got %b want 0", changeIrq);
    end
    reset = 1'b0;
    repeat (10) tick();
    tests_run++;
    if (changeIrq !== 1'b0) begin
      tests_failed++;
      $display("FAIL warmup_no_flags: got %b want 0", changeIrq);
    end
    bus_read(32'hFFFF_FFE8);
    tests_run++;
    if (readData !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL read_port2_const: got %h want ffffffff", readData);
    end
  endtask

  task automatic test_decode();
    logic [31:0] addrs [5];
    logic        exp   [5];
    addrs = '{32'hFFFF_FFDC, 32'hFFFF_FFD8, 32'hFFFF_FFE0, 32'hFFFF_FFFC, 32'h0000_1000};
    exp   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      set_addr(addrs[i]);
      #1;
      tests_run++;
      if (hit !== exp[i]) begin
        tests_failed++;
        $display("FAIL hit_decode addr=%h: got %b want %b", addrs[i], hit, exp[i]);
      end
    end
  endtask

  task automatic test_byte_write();
    bus_write(32'hFFFF_FFE4, 32'hA5A5_A5A5, 4'b0101);
    tests_run++;
    if (mmioOutputs[32*1 +: 32] !== 32'h00A5_00A5) begin
      tests_failed++;
      $display("FAIL byte_write_p1: got %h want 00a500a5", mmioOutputs[32*1 +: 32]);
    end
    bus_write(32'hFFFF_FFE0, 32'hDEAD_BEEF, 4'hF);
    bus_write(32'hFFFF_FFE0, 32'h0000_1100, 4'b0010);
    tests_run++;
    if (mmioOutputs[32*0 +: 32] !== 32'hDEAD_11EF) begin
      tests_failed++;
      $display("FAIL byte_write_p0: got %h want dead11ef", mmioOutputs[32*0 +: 32]);
    end
    bus_write(32'hFFFF_FFFC, 32'h5A00_0000, 4'b1000);
    tests_run++;
    if (mmioOutputs[32*7 +: 32] !== 32'h5A00_0000) begin
      tests_failed++;
      $display("FAIL byte_write_p7: got %h want 5a000000", mmioOutputs[32*7 +: 32]);
    end
    tests_run++;
    if (mmioOutputs[32*1 +: 32] !== 32'h00A5_00A5) begin
      tests_failed++;
      $display("FAIL write_isolation_p1: got %h want 00a500a5", mmioOutputs[32*1 +: 32]);
    end
  endtask

  task automatic test_read_input();
    mmioInputs[32*7 +: 32] = 32'h1234_5678;
    repeat (3) tick();
    set_addr(32'hFFFF_FFFC);
    readEnable = 1'b1;
    #1;
    tests_run++;
    if (readData !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL read_latency_early: got %h want ffffffff", readData);
    end
    tick();
    readEnable = 1'b0;
    tests_run++;
    if (readData !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL read_port7: got %h want 12345678", readData);
    end
    set_addr(32'hFFFF_FFE8);
    repeat (2) tick();
    tests_run++;
    if (readData !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL read_hold: got %h want 12345678", readData);
    end
  endtask

  task automatic test_read_write_same();
    set_addr(32'hFFFF_FFF8);
    writeData   = 32'hCAFE_F00D;
    byteEnable  = 4'hF;
    writeEnable = 1'b1;
    readEnable  = 1'b1;
    tick();
    writeEnable = 1'b0;
    readEnable  = 1'b0;
    byteEnable  = 4'h0;
    tests_run++;
    if (readData !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL rw_same_read: got %h want ffffffff", readData);
    end
    tests_run++;
    if (mmioOutputs[32*6 +: 32] !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL rw_same_write: got %h want cafef00d", mmioOutputs[32*6 +: 32]);
    end
  endtask

  task automatic test_miss();
    set_addr(32'h0000_1000);
    readEnable = 1'b1;
    #1;
    tests_run++;
    if (hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL miss_hit: got %b want 0", hit);
    end
    tick();
    readEnable = 1'b0;
    tests_run++;
    if (readData !== 32'h0) begin
      tests_failed++;
      $display("FAIL miss_readdata: got %h want 0", readData);
    end
    bus_write(32'h0000_1000, 32'h0000_0000, 4'hF);
    bus_write(32'hFFFF_FFD8, 32'h0000_0000, 4'hF);
    tests_run++;
    if (mmioOutputs[32*0 +: 32] !== 32'hDEAD_11EF) begin
      tests_failed++;
      $display("FAIL miss_write_p0: got %h want dead11ef", mmioOutputs[32*0 +: 32]);
    end
    tests_run++;
    if (mmioOutputs[32*6 +: 32] !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL miss_write_p6: got %h want cafef00d", mmioOutputs[32*6 +: 32]);
    end
  endtask

`ifdef JZJPCC_MMIO_CHANGE_DETECT_EN
  task automatic test_change_detect();
    // Port 7 changed earlier; clear everything first.
    bus_write(32'hFFFF_FFDC, 32'hFFFF_FFFF, 4'hF);
    tests_run++;
    if (changeIrq !== 1'b0) begin
      tests_failed++;
      $display("FAIL w1c_clear_all: got %b want 0", changeIrq);
    end
    mmioInputs[32*3 +: 32] = 32'hFFFF_FFFE;
    repeat (2) tick();
    tests_run++;
    if (changeIrq !== 1'b0) begin
      tests_failed++;
      $display("FAIL change_early: got %b want 0", changeIrq);
    end
    tick();
    tests_run++;
    if (changeIrq !== 1'b1) begin
      tests_failed++;
      $display("FAIL change_irq: got %b want 1", changeIrq);
    end
    bus_read(32'hFFFF_FFDC);
    tests_run++;
    if (readData !== 32'h0000_0008) begin
      tests_failed++;
      $display("FAIL status_read: got %h want 00000008", readData);
    end
    bus_write(32'hFFFF_FFDC, 32'h0000_0008, 4'b1110);
    tests_run++;
    if (changeIrq !== 1'b1) begin
      tests_failed++;
      $display("FAIL w1c_lane_off: got %b want 1", changeIrq);
    end
    bus_write(32'hFFFF_FFDC, 32'h0000_0008, 4'b0001);
    tests_run++;
    if (changeIrq !== 1'b0) begin
      tests_failed++;
      $display("FAIL w1c_lane_on: got %b want 0", changeIrq);
    end
    // Same-cycle set and clear: set wins.
    mmioInputs[32*3 +: 32] = 32'hFFFF_FFFF;
    repeat (2) tick();
    bus_write(32'hFFFF_FFDC, 32'h0000_0008, 4'hF);
    tests_run++;
    if (changeIrq !== 1'b1) begin
      tests_failed++;
      $display("FAIL set_wins: got %b want 1", changeIrq);
    end
    bus_write(32'hFFFF_FFDC, 32'h0000_0008, 4'hF);
    tests_run++;
    if (changeIrq !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_after_set: got %b want 0", changeIrq);
    end
    // Two flags; clearing one leaves the other.
    mmioInputs[32*3 +: 32] = 32'h0000_0000;
    mmioInputs[32*5 +: 32] = 32'h0000_0000;
    repeat (3) tick();
    bus_write(32'hFFFF_FFDC, 32'h0000_0008, 4'hF);
    bus_read(32'hFFFF_FFDC);
    tests_run++;
    if (readData !== 32'h0000_0020) begin
      tests_failed++;
      $display("FAIL w1c_selective: got %h want 00000020", readData);
    end
    bus_write(32'hFFFF_FFDC, 32'hFFFF_FFFF, 4'hF);
  endtask
`else
  task automatic test_status_disabled();
    bus_write(32'hFFFF_FFDC, 32'hFFFF_FFFF, 4'hF);
    bus_read(32'hFFFF_FFDC);
    tests_run++;
    if (readData !== 32'h0) begin
      tests_failed++;
      $display("FAIL status_zero: got %h want 0", readData);
    end
    tests_run++;
    if (changeIrq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_tied: got %b want 0", changeIrq);
    end
    tests_run++;
    if (mmioOutputs[32*0 +: 32] !== 32'hDEAD_11EF) begin
      tests_failed++;
      $display("FAIL status_write_ignored: got %h want dead11ef", mmioOutputs[32*0 +: 32]);
    end
  endtask
`endif

  task automatic test_reset_mid();
    set_addr(32'hFFFF_FFE8);
    writeData   = 32'h1111_1111;
    byteEnable  = 4'hF;
    writeEnable = 1'b1;
    readEnable  = 1'b1;
    reset       = 1'b1;
    tick();
    reset       = 1'b0;
    writeEnable = 1'b0;
    byteEnable  = 4'h0;
    tests_run++;
    if (mmioOutputs !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got %h want 0", mmioOutputs);
    end
    tests_run++;
    if (readData !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_readdata: got %h want 0", readData);
    end
    // First read after release samples the cleared chain.
    set_addr(32'hFFFF_FFFC);
    tick();
    readEnable = 1'b0;
    tests_run++;
    if (readData !== 32'h0) begin
      tests_failed++;
      $display("FAIL sync_reset: got %h want 0", readData);
    end
    repeat (10) tick();
    tests_run++;
    if (changeIrq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_warmup: got %b want 0", changeIrq);
    end
  endtask

  initial begin
    address     = '0;
    readEnable  = 1'b0;
    writeEnable = 1'b0;
    byteEnable  = 4'h0;
    writeData   = '0;
    reset       = 1'b1;
    mmioInputs  = '0;
    test_reset();
    test_decode();
    test_byte_write();
    test_read_input();
    test_read_write_same();
    test_miss();
`ifdef JZJPCC_MMIO_CHANGE_DETECT_EN
    test_change_detect();
`else
    test_status_disabled();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jzjpcc_mmio_bank.md
JZJPCC_MMIO_BANK -- requirements
Module: jzjpcc_mmio_bank

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 8, meaning the number of 32-bit input/output port pairs; legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the input synchroniser depth; legal range 2..4.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port address, input, 30 ([31:2]), the word address.
REQ-006 SHALL have port readEnable, input, 1, read strobe.
REQ-007 SHALL have port writeEnable, input, 1, write strobe.
REQ-008 SHALL have port byteEnable, input, 4, per-byte write lanes (bit n selects writeData[8n+7:8n]).
REQ-009 SHALL have port writeData, input, 32, store data.
REQ-010 SHALL have port readData, output, 32, registered load data.
REQ-011 SHALL have port hit, output, 1, combinational flag: address falls inside the bank window.
REQ-012 SHALL have port mmioInputs, input, 32 x NUM_PORTS, external inputs.
REQ-013 SHALL have port mmioOutputs, output, 32 x NUM_PORTS, output registers.
REQ-014 SHALL have port changeIrq, output, 1, OR of all change flags.

Function
REQ-015 Port i SHALL occupy byte address BASE + 4*i, with BASE = 2^32 - 4*NUM_PORTS; the status word SHALL be at BASE - 4. For the default of 8 ports: FFFFFFE0..FFFFFFFC, status at FFFFFFDC.
REQ-016 hit SHALL be 1 exactly when address decodes to a port word or to the status word.
REQ-017 A write with writeEnable=1 to port i SHALL update only the mmioOutputs[i] bytes whose byteEnable bit is 1, visible the cycle after the edge.
REQ-018 A read with readEnable=1 SHALL present data on readData one cycle later (latency 1): the synchronised mmioInputs[i] for port i, the change-flag vector (bits NUM_PORTS-1:0, upper bits zero) for the status word. readData SHALL hold its value when readEnable=0.
REQ-019 A read or write that misses (hit=0) SHALL change no state; a missed read SHALL load readData with 0.
REQ-020 Each mmioInputs[i] SHALL pass through a SYNC_STAGES-deep flop chain; reads and change detection SHALL use only the last stage.
REQ-021 Warm-up: a counter SHALL count SYNC_STAGES cycles after reset, and change detection SHALL stay suppressed until it saturates.
REQ-022 After warm-up, change flag i SHALL set when the last synchroniser stage of port i differs from its value on the previous cycle.
REQ-023 A write to the status word SHALL clear each flag whose writeData bit is 1 and whose byte lane is enabled (write-1-to-clear); flags with a 0 bit SHALL be unaffected.
REQ-024 If a flag's set and clear occur in the same cycle, set SHALL win.
REQ-025 Simultaneous readEnable and writeEnable to the same port SHALL return the input value; output and input are independent.

Reset
REQ-026 While reset=1 at an edge: mmioOutputs, all synchroniser stages, change flags, warm-up counter and readData SHALL become 0, and changeIrq SHALL read 0 on the following cycle.
REQ-027 Reset asserted mid-transaction SHALL discard the pending write and read; reset SHALL take priority over all other updates.

Configuration
REQ-028 With macro JZJPCC_MMIO_CHANGE_DETECT_EN defined, REQ-021..REQ-024 SHALL be implemented.
REQ-029 Without JZJPCC_MMIO_CHANGE_DETECT_EN, there SHALL be no flags or warm-up counter, the status word SHALL read 0, writes to it SHALL be ignored, hit SHALL still cover it, and changeIrq SHALL be tied to 0.

Structure
REQ-030 Package jzjpcc_mmio_pkg SHALL hold the constants MMIO_TOP_ADDR (32'hFFFFFFFC) and MAX_PORTS (32), plus the function computing BASE from NUM_PORTS.
REQ-031 Sub-module jzjpcc_sync_chain SHALL implement one parameter-width, SYNC_STAGES-deep synchroniser and be instantiated once per port.

Verification
REQ-032 Write FFFFFFE4, data 0xA5A5A5A5, byteEnable 4'b0101 after reset: mmioOutputs[1] SHALL equal 0x00A500A5 next cycle.
REQ-033 Drive mmioInputs[7]=0x12345678, wait SYNC_STAGES+1 cycles, then read FFFFFFFC: readData SHALL equal 0x12345678 exactly one cycle after the read.
REQ-034 With change detection enabled, toggle mmioInputs[3] bit 0 after warm-up: after SYNC_STAGES+1 cycles changeIrq=1, and a status read SHALL return 0x00000008.
REQ-035 Write 0x00000008 to FFFFFFDC in the same cycle port 3 sees a new change: flag 3 SHALL remain 1; a later write with no new change SHALL clear it and drop changeIrq.
REQ-036 Read 0x00001000: hit SHALL be 0, readData SHALL be 0, and no state SHALL change.
REQ-037 Assert reset while mmioInputs are all 0xFFFFFFFF and a write to FFFFFFE0 is presented: outputs SHALL be 0, and no flags SHALL set during or after warm-up while the inputs stay constant.
